// File: rtl/cache_types_pkg.sv
// Shared types for the L1 cache controller: FSM state encoding, pmem address
// select codes and the victim-dirty helper.
package cache_types_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TAG_COMP  = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } cache_state_t;

  localparam logic [1:0] PMEM_SEL_CPU  = 2'd0;
  localparam logic [1:0] PMEM_SEL_WAY0 = 2'd1;
  localparam logic [1:0] PMEM_SEL_WAY1 = 2'd2;

  // lru=1 names way0 as the victim, lru=0 names way1.
  function automatic logic victim_dirty(input logic lru, input logic v0, input logic d0,
                                        input logic v1, input logic d1);
    return lru ? (v0 & d0) : (v1 & d1);
  endfunction

endpackage

// File: rtl/cache_control_if.sv
// Control/status bundle between the cache controller, the hit/select datapath
// and the physical-memory port.
interface cache_control_if;
  logic       mem_read;
  logic       mem_write;
  logic       hit_resp;
  logic       lru;
  logic       valid0;
  logic       valid1;
  logic       dirty0;
  logic       dirty1;
  logic       pmem_resp;
  logic       tag_comp;
  logic       idling;
  logic       alloc_dirty0_write;
  logic       alloc_dirty1_write;
  logic       valid0_wr;
  logic       valid1_wr;
  logic       tag0_wr;
  logic       tag1_wr;
  logic       dirty_in;
  logic       pmem_read;
  logic       pmem_write;
  logic [1:0] pmem_addr_sel;
  logic       wb_data_sel;

  modport master (
    output mem_read, mem_write, hit_resp, lru, valid0, valid1, dirty0, dirty1, pmem_resp,
    input  tag_comp, idling, alloc_dirty0_write, alloc_dirty1_write, valid0_wr, valid1_wr,
           tag0_wr, tag1_wr, dirty_in, pmem_read, pmem_write, pmem_addr_sel, wb_data_sel
  );

  modport slave (
    input  mem_read, mem_write, hit_resp, lru, valid0, valid1, dirty0, dirty1, pmem_resp,
    output tag_comp, idling, alloc_dirty0_write, alloc_dirty1_write, valid0_wr, valid1_wr,
           tag0_wr, tag1_wr, dirty_in, pmem_read, pmem_write, pmem_addr_sel, wb_data_sel
  );
endinterface

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter; clear wins over increment, holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next-count selection
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache: hit handling, victim
// writeback, line refill and hit/miss/writeback performance counters.
module cache_control
  import cache_types_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_counters,
  cache_control_if.slave       bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  cache_state_t state_q;
  cache_state_t state_d;
  logic         req_s;
  logic         hit_inc_s;
  logic         miss_inc_s;
  logic         wb_inc_s;
  logic         fill0_s;
  logic         fill1_s;

  assign req_s = bus.mem_read | bus.mem_write;

  // next-state and Moore output decode; fill strobes are the only pmem_resp-gated outputs
  always_comb begin
    state_d            = state_q;
    bus.idling         = 1'b0;
    bus.tag_comp       = 1'b0;
    bus.pmem_read      = 1'b0;
    bus.pmem_write     = 1'b0;
    bus.pmem_addr_sel  = PMEM_SEL_CPU;
    bus.dirty_in       = 1'b1;
    fill0_s            = 1'b0;
    fill1_s            = 1'b0;
    case (state_q)
      IDLE: begin
        bus.idling = 1'b1;
        if (req_s && !bus.hit_resp) state_d = TAG_COMP;
        else                        state_d = IDLE;
      end
      TAG_COMP: begin
        bus.tag_comp = 1'b1;
        if (!req_s || bus.hit_resp) begin
          state_d = IDLE;
        end else if (victim_dirty(bus.lru, bus.valid0, bus.dirty0, bus.valid1, bus.dirty1)) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = bus.lru ? PMEM_SEL_WAY0 : PMEM_SEL_WAY1;
        if (bus.pmem_resp) state_d = ALLOCATE;
        else               state_d = WRITEBACK;
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        bus.dirty_in  = 1'b0;
        if (bus.pmem_resp) begin
          fill0_s = bus.lru;
          fill1_s = ~bus.lru;
          state_d = TAG_COMP;
        end else begin
          state_d = ALLOCATE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wb_data_sel        = ~bus.lru;
  assign bus.alloc_dirty0_write = fill0_s;
  assign bus.valid0_wr          = fill0_s;
  assign bus.tag0_wr            = fill0_s;
  assign bus.alloc_dirty1_write = fill1_s;
  assign bus.valid1_wr          = fill1_s;
  assign bus.tag1_wr            = fill1_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign hit_inc_s  = (state_q == IDLE) & req_s & bus.hit_resp;
  assign miss_inc_s = (state_q == IDLE) & req_s & ~bus.hit_resp;
  assign wb_inc_s   = (state_q == TAG_COMP) & (state_d == WRITEBACK);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .rst(rst), .clr(clear_counters), .inc(hit_inc_s), .count(hit_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst(rst), .clr(clear_counters), .inc(miss_inc_s), .count(miss_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .rst(rst), .clr(clear_counters), .inc(wb_inc_s), .count(wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed scoreboard bench for cache_control; counters use a narrow width so
// saturation is reachable with a short run of hits.
module tb_cache_control;
  import cache_types_pkg::*;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          clear_counters;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] wb_count;

  cache_control_if bus ();

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clear_counters(clear_counters), .bus(bus.slave),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {idling,tag_comp,pmem_read,pmem_write,addr_sel[1:0],wb_data_sel,dirty_in,
  //  alloc_dirty0,valid0_wr,tag0_wr,alloc_dirty1,valid1_wr,tag1_wr}
  typedef struct {
    string         name;
    logic [13:0]   ctl;
    logic [CW-1:0] hc;
    logic [CW-1:0] mc;
    logic [CW-1:0] wc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_out(input string name, input logic idl, input logic tc,
                            input logic pr, input logic pw, input logic [1:0] sel,
                            input logic wbs, input logic din, input logic s0, input logic s1,
                            input int hc, input int mc, input int wc);
    exp_t e;
    e.name = name;
    e.ctl  = {idl, tc, pr, pw, sel, wbs, din, s0, s0, s0, s1, s1, s1};
    e.hc   = CW'(hc);
    e.mc   = CW'(mc);
    e.wc   = CW'(wc);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitor: compare each queued expectation against the DUT mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e = exp_q.pop_front();
      act = {bus.idling, bus.tag_comp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel,
             bus.wb_data_sel, bus.dirty_in, bus.alloc_dirty0_write, bus.valid0_wr, bus.tag0_wr,
             bus.alloc_dirty1_write, bus.valid1_wr, bus.tag1_wr};
      n_checks++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      n_checks++;
      if ({hit_count, miss_count, wb_count} !== {e.hc, e.mc, e.wc}) begin
        n_fail++;
        $display("FAIL %s counters(h/m/w): got %0d/%0d/%0d expected %0d/%0d/%0d",
                 e.name, hit_count, miss_count, wb_count, e.hc, e.mc, e.wc);
      end
    end
  end

  initial begin
    rst = 1'b1; clear_counters = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit_resp = 1'b0; bus.lru = 1'b1;
    bus.valid0 = 1'b0; bus.valid1 = 1'b0; bus.dirty0 = 1'b0; bus.dirty1 = 1'b0;
    bus.pmem_resp = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    expect_out("reset", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0);

    // 1: read hit in IDLE, zero added latency
    cyc(); bus.mem_read = 1'b1; bus.hit_resp = 1'b1;
    expect_out("hit_idle", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0);
    cyc(); bus.mem_read = 1'b0; bus.hit_resp = 1'b0;
    expect_out("hit_count", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 1, 0, 0);

    // 2: clean miss, victim way0
    cyc(); bus.mem_read = 1'b1; bus.lru = 1'b1; bus.valid0 = 1'b0;
    expect_out("clean_req", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 1, 0, 0);
    cyc();
    expect_out("clean_tagcomp", 0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      expect_out("clean_alloc_wait", 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0);
    end
    cyc(); bus.pmem_resp = 1'b1;
    expect_out("clean_fill_way0", 0, 0, 1, 0, 2'd0, 0, 0, 1, 0, 1, 1, 0);
    cyc(); bus.pmem_resp = 1'b0; bus.hit_resp = 1'b1;
    expect_out("clean_retag", 0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 1, 1, 0);
    cyc(); bus.mem_read = 1'b0; bus.hit_resp = 1'b0;
    expect_out("clean_done", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 1, 1, 0);

    // 3: dirty miss, victim way1 (write request)
    cyc(); bus.mem_write = 1'b1; bus.lru = 1'b0; bus.valid1 = 1'b1; bus.dirty1 = 1'b1;
    bus.valid0 = 1'b1;
    expect_out("dirty_req", 1, 0, 0, 0, 2'd0, 1, 1, 0, 0, 1, 1, 0);
    cyc();
    expect_out("dirty_tagcomp", 0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 1, 2, 0);
    cyc();
    expect_out("dirty_wb", 0, 0, 0, 1, PMEM_SEL_WAY1, 1, 1, 0, 0, 1, 2, 1);
    cyc(); bus.pmem_resp = 1'b1;
    expect_out("dirty_wb_resp", 0, 0, 0, 1, PMEM_SEL_WAY1, 1, 1, 0, 0, 1, 2, 1);
    cyc();
    expect_out("dirty_fill_way1", 0, 0, 1, 0, 2'd0, 1, 0, 0, 1, 1, 2, 1);
    cyc(); bus.pmem_resp = 1'b0; bus.hit_resp = 1'b1;
    expect_out("dirty_retag", 0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 1, 2, 1);
    cyc(); bus.mem_write = 1'b0; bus.hit_resp = 1'b0; bus.lru = 1'b1;
    expect_out("dirty_done", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 1, 2, 1);

    // 4: reset in WRITEBACK, victim way0 this time
    cyc(); bus.mem_read = 1'b1; bus.dirty0 = 1'b1;
    cyc();
    expect_out("rst_tagcomp", 0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 1, 3, 1);
    cyc(); rst = 1'b1;
    expect_out("rst_in_wb", 0, 0, 0, 1, PMEM_SEL_WAY0, 0, 1, 0, 0, 1, 3, 2);
    cyc(); rst = 1'b0; bus.mem_read = 1'b0; bus.dirty0 = 1'b0;
    expect_out("rst_after", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0);

    // 5: request dropped in TAG_COMP, then stray pmem_resp in IDLE
    cyc(); bus.mem_read = 1'b1; bus.valid0 = 1'b0;
    cyc(); bus.mem_read = 1'b0;
    expect_out("drop_tagcomp", 0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 0, 1, 0);
    cyc(); bus.pmem_resp = 1'b1;
    expect_out("stray_resp", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 1, 0);
    cyc(); bus.pmem_resp = 1'b0;
    expect_out("stray_after", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 1, 0);

    // 6: saturate hit_count, then clear together with a hit
    cyc(); bus.mem_read = 1'b1; bus.hit_resp = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    expect_out("hit_saturated", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 15, 1, 0);
    cyc(); clear_counters = 1'b1;
    expect_out("clear_with_hit", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 15, 1, 0);
    cyc(); clear_counters = 1'b0; bus.mem_read = 1'b0; bus.hit_resp = 1'b0;
    expect_out("cleared", 1, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
